// File: rtl/clk_div_monitor_if.sv
// Bus between clk_div_monitor and whatever drives the divided clock / reads its status.
// The monitor side is the slave modport; state_dbg exposes the FSM state.
interface clk_div_monitor_if #(
    parameter int CNT_W = 8
);
    logic             clk_div_i;
    logic             clr_i;
    logic [CNT_W-1:0] period_o;
    logic             period_vld_o;
    logic             lock_o;
    logic             err_o;
    logic             stuck_o;
    logic [1:0]       state_dbg;

    modport master (
        output clk_div_i,
        output clr_i,
        input  period_o,
        input  period_vld_o,
        input  lock_o,
        input  err_o,
        input  stuck_o,
        input  state_dbg
    );

    modport slave (
        input  clk_div_i,
        input  clr_i,
        output period_o,
        output period_vld_o,
        output lock_o,
        output err_o,
        output stuck_o,
        output state_dbg
    );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures the period of a divided clock in clk_i cycles and reports lock/error/stuck.
// Define CLK_DIV_MON_TOLERANCE_EN to accept periods within +/-1 of EXP_PERIOD.
module clk_div_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 4,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                clk_i,
    input  logic                rst,
    clk_div_monitor_if.slave    bus
);
    localparam int              MW     = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
    localparam logic [MW-1:0]    LOCK_C  = MW'(LOCK_CNT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic [MW-1:0]    mcnt;
    logic [MW-1:0]    mcnt_nxt;
    logic             match;

    assign rise          = s2 & ~s3;
    assign mcnt_nxt      = mcnt + MW'(1);
    assign bus.state_dbg = state;

`ifdef CLK_DIV_MON_TOLERANCE_EN
    assign match = (cnt >= EXP_C - CNT_W'(1)) && (cnt <= EXP_C + CNT_W'(1));
`else
    assign match = (cnt == EXP_C);
`endif

    // s1 is the metastability flop; s2/s3 are clean and feed the edge detector.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s3  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= bus.clk_div_i;
            s2 <= s1;
            s3 <= s2;
            if (rise)
                cnt <= CNT_W'(1);
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state            <= SEARCH;
            mcnt             <= '0;
            bus.period_o     <= '0;
            bus.period_vld_o <= 1'b0;
            bus.lock_o       <= 1'b0;
            bus.err_o        <= 1'b0;
            bus.stuck_o      <= 1'b0;
        end else begin
            bus.period_vld_o <= 1'b0;
            // A mismatch assignment further down overrides this clear.
            if (bus.clr_i)
                bus.err_o <= 1'b0;
            case (state)
                SEARCH: begin
                    if (rise) begin
                        state       <= TRACK;
                        mcnt        <= '0;
                        bus.stuck_o <= 1'b0;
                    end
                end
                TRACK: begin
                    if (rise) begin
                        bus.period_o     <= cnt;
                        bus.period_vld_o <= 1'b1;
                        if (match) begin
                            mcnt <= mcnt_nxt;
                            if (mcnt_nxt == LOCK_C) begin
                                state      <= LOCKED;
                                bus.lock_o <= 1'b1;
                            end
                        end else begin
                            mcnt <= '0;
                        end
                    end else if (cnt == TO_C) begin
                        bus.stuck_o <= 1'b1;
                        state       <= SEARCH;
                        mcnt        <= '0;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        bus.period_o     <= cnt;
                        bus.period_vld_o <= 1'b1;
                        if (!match) begin
                            bus.err_o  <= 1'b1;
                            mcnt       <= '0;
                            state      <= TRACK;
                            bus.lock_o <= 1'b0;
                        end
                    end else if (cnt == TO_C) begin
                        bus.stuck_o <= 1'b1;
                        state       <= SEARCH;
                        mcnt        <= '0;
                        bus.lock_o  <= 1'b0;
                    end
                end
                default: begin
                    state      <= SEARCH;
                    mcnt       <= '0;
                    bus.lock_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
